stream_upsizer_pow2: RTL and testbench

- Downstream consumer of the rollback FIFO's down_* stream.
- Packs RATIO consecutive D_WIDTH-bit words into one wide word.
- Drives a single registered wide output with valid/ready handshake and a lane count.
- A level-sensitive flush input drains partially filled groups at end of burst or packet.

---
 rtl/stream_upsizer_pow2.sv | 94 +++++++++
 tb/tb_stream_upsizer_pow2.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/stream_upsizer_pow2.sv
// rtl/stream_upsizer_pow2.sv - packs 2**RATIO_LOG2 narrow stream words into one wide registered word.
// A level flush emits a partial group, with its lane count, as soon as the output slot is free.
module stream_upsizer_pow2 #(
  parameter int D_WIDTH    = 6,
  parameter int RATIO_LOG2 = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [D_WIDTH-1:0]                up_data,
  input  logic                              up_valid,
  output logic                              up_ready,
  input  logic                              flush,
  output logic [(D_WIDTH<<RATIO_LOG2)-1:0]  down_data,
  output logic [RATIO_LOG2:0]               down_count,
  output logic                              down_valid,
  input  logic                              down_ready
);

  localparam int RATIO = 1 << RATIO_LOG2;
  localparam int W     = D_WIDTH * RATIO;
  localparam int NW    = RATIO_LOG2 + 1;

  logic [RATIO_LOG2-1:0] cnt_q, cnt_d;
  logic [W-1:0]          acc_q, acc_d;
  logic [W-1:0]          data_q, data_d;
  logic [NW-1:0]         count_q, count_d;
  logic                  valid_q, valid_d;

  logic          slot_free, last, up_fire, down_fire, load;
  logic [W-1:0]  merged;
  logic [NW-1:0] cnt_ext;

  assign slot_free = !valid_q | down_ready;
  assign last      = (cnt_q == RATIO_LOG2'(RATIO - 1));
  // Only a word that would need the output slot is gated; never looks at up_valid.
  assign up_ready  = (last | flush) ? slot_free : 1'b1;
  assign up_fire   = up_valid & up_ready;
  assign down_fire = valid_q & down_ready;
  assign cnt_ext   = {1'b0, cnt_q};
  assign load      = (up_fire & last) | (flush & slot_free & (up_fire | (cnt_q != '0)));

  always_comb begin
    merged = acc_q;
    for (int i = 0; i < RATIO; i++) begin
      if (up_fire && (32'(cnt_q) == i)) begin
        merged[i*D_WIDTH +: D_WIDTH] = up_data;
      end
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    count_d = count_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = merged;
      count_d = up_fire ? (cnt_ext + NW'(1)) : cnt_ext;
      valid_d = 1'b1;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      if (up_fire) begin
        acc_d = merged;
        cnt_d = cnt_q + RATIO_LOG2'(1);
      end
      if (down_fire) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign down_data  = data_q;
  assign down_count = count_q;
  assign down_valid = valid_q;

endmodule

// File: tb/tb_stream_upsizer_pow2.sv
// tb/tb_stream_upsizer_pow2.sv - directed bench for stream_upsizer_pow2 with a queue-based reference model.
module tb_stream_upsizer_pow2;

  localparam int D  = 6;
  localparam int RL = 2;
  localparam int R  = 1 << RL;
  localparam int W  = D * R;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [D-1:0] up_data = '0;
  logic         up_valid = 1'b0;
  logic         up_ready;
  logic         flush = 1'b0;
  logic [W-1:0] down_data;
  logic [RL:0]  down_count;
  logic         down_valid;
  logic         down_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  // Reference: words of the current group in arrival order, plus the expected output register.
  int           grp[$];
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  int           m_count = 0;

  stream_upsizer_pow2 #(.D_WIDTH(D), .RATIO_LOG2(RL)) dut (
    .clk(clk), .rst(rst),
    .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
    .flush(flush),
    .down_data(down_data), .down_count(down_count), .down_valid(down_valid),
    .down_ready(down_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack_grp();
    logic [W-1:0] v = '0;
    for (int i = 0; i < grp.size(); i++) v = v | (W'(grp[i]) << (i * D));
    return v;
  endfunction

  // Drive one cycle of inputs, check up_ready, advance the model, then check registered outputs.
  task automatic step(input logic uv, input int ud, input logic fl, input logic dr);
    logic slot_free, exp_ready, fire;
    up_valid = uv; up_data = D'(ud); flush = fl; down_ready = dr;
    #1;
    slot_free = !m_valid || dr;
    exp_ready = (grp.size() == R - 1 || fl) ? slot_free : 1'b1;
    chk("up_ready", 64'(up_ready), 64'(exp_ready));
    fire = uv && exp_ready;
    if (fire) grp.push_back(ud);
    if (grp.size() == R || (fl && slot_free && grp.size() > 0)) begin
      m_valid = 1'b1;
      m_data  = pack_grp();
      m_count = grp.size();
      grp.delete();
    end else if (m_valid && dr) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("down_valid", 64'(down_valid), 64'(m_valid));
    if (m_valid) begin
      chk("down_data", 64'(down_data), 64'(m_data));
      chk("down_count", 64'(down_count), 64'(m_count));
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(down_valid), 64'd0);
    chk("rst_data", 64'(down_data), 64'd0);
    chk("rst_count", 64'(down_count), 64'd0);
    chk("rst_up_ready", 64'(up_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full burst
    for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b1);
    chk("burst_lit_data", 64'(down_data), 64'h103081);
    chk("burst_lit_count", 64'(down_count), 64'd4);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("burst_drop", 64'(down_valid), 64'd0);

    // Backpressure: second group's completing word stalls until the slot frees
    for (int i = 1; i <= 7; i++) step(1'b1, i, 1'b0, 1'b0);
    chk("bp_hold_data", 64'(down_data), 64'h103081);
    for (int i = 0; i < 3; i++) step(1'b1, 8, 1'b0, 1'b0);
    chk("bp_stall_ready", 64'(up_ready), 64'd0);
    step(1'b1, 8, 1'b0, 1'b1);
    chk("bp_lit_data", 64'(down_data), 64'h207185);
    chk("bp_lit_count", 64'(down_count), 64'd4);
    step(1'b0, 0, 1'b0, 1'b1);

    // Partial flush, then a new word must land in lane 0
    step(1'b1, 'h3F, 1'b0, 1'b1);
    step(1'b1, 'h01, 1'b0, 1'b1);
    step(1'b0, 0, 1'b1, 1'b1);
    chk("pflush_lit_data", 64'(down_data), 64'h7F);
    chk("pflush_lit_count", 64'(down_count), 64'd2);
    step(1'b1, 'h05, 1'b0, 1'b1);
    step(1'b0, 0, 1'b1, 1'b1);
    chk("pflush_lane0", 64'(down_data), 64'h05);
    step(1'b0, 0, 1'b0, 1'b1);

    // Flush together with an accepted word
    step(1'b1, 'h0A, 1'b0, 1'b1);
    step(1'b1, 'h15, 1'b1, 1'b1);
    chk("fsim_lit_data", 64'(down_data), 64'h54A);
    chk("fsim_lit_count", 64'(down_count), 64'd2);
    step(1'b0, 0, 1'b0, 1'b1);

    // Idle flush
    for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b1, 1'b1);
    chk("idle_lit_valid", 64'(down_valid), 64'd0);

    // Drain mode under intermittent backpressure
    for (int i = 0; i < 12; i++) step(1'b1, 20 + i, 1'b1, 1'(i % 3 != 1));
    step(1'b0, 0, 1'b1, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);

    // Flush arriving while a partial group waits behind a held output
    for (int i = 1; i <= 6; i++) step(1'b1, 'h30 + i, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b1);
    chk("fbp_lit_count", 64'(down_count), 64'd2);
    step(1'b0, 0, 1'b0, 1'b1);

    // Reset mid-group with a held output word
    for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b0);
    step(1'b1, 'h11, 1'b0, 1'b0);
    step(1'b1, 'h22, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(down_valid), 64'd0);
    chk("arst_count", 64'(down_count), 64'd0);
    chk("arst_data", 64'(down_data), 64'd0);
    grp.delete();
    m_valid = 1'b0;
    up_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b1);
    chk("arst_lit_data", 64'(down_data), 64'h103081);
    step(1'b0, 0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
